// File: rtl/sobel_window_generator.sv
// sobel_window_generator
// Raster-order pixel streamer that assembles the 3x3 neighbourhood consumed
// by the Sobel gradient datapath. It uses two line buffers (rows r-1 and r-2)
// and a 3x3 shift window. For every interior position it presents a
// registered window together with a one-cycle start_calculations pulse.

module sobel_window_generator #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIX_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_in,
    input  logic             pixel_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] windowBuffer [0:8],
    output logic             start_calculations,
    output logic             frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_MIN_V = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_MIN_V = ROW_W'(2);

    // Position counters: the position the next accepted pixel will take.
    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;

    // Position of the pixel on the input this cycle (sof forces the origin).
    logic [COL_W-1:0] cur_col_s;
    logic [ROW_W-1:0] cur_row_s;
    logic [COL_W-1:0] next_col_s;
    logic [ROW_W-1:0] next_row_s;

    // Line buffers: lb1 holds row r-1, lb0 holds row r-2, indexed by column.
    logic [PIX_W-1:0] lb0_r [0:IMG_WIDTH-1];
    logic [PIX_W-1:0] lb1_r [0:IMG_WIDTH-1];
    logic [PIX_W-1:0] lb0_rd_s;
    logic [PIX_W-1:0] lb1_rd_s;

    // Internal shift window (shifts on every accept) and its next value.
    logic [PIX_W-1:0] win_r      [0:8];
    logic [PIX_W-1:0] win_next_s [0:8];

    logic win_valid_s;
    logic last_pix_s;

    // Resolve the current position and the position that follows it.
    always_comb begin
        cur_col_s   = col_r;
        cur_row_s   = row_r;
        next_col_s  = col_r;
        next_row_s  = row_r;

        if (sof) begin
            cur_col_s = {COL_W{1'b0}};
            cur_row_s = {ROW_W{1'b0}};
        end else begin
            cur_col_s = col_r;
            cur_row_s = row_r;
        end

        if (cur_col_s == COL_LAST) begin
            next_col_s = {COL_W{1'b0}};
            if (cur_row_s == ROW_LAST) begin
                next_row_s = {ROW_W{1'b0}};
            end else begin
                next_row_s = cur_row_s + ROW_W'(1);
            end
        end else begin
            next_col_s = cur_col_s + COL_W'(1);
            next_row_s = cur_row_s;
        end

        win_valid_s = (cur_row_s >= ROW_MIN_V) && (cur_col_s >= COL_MIN_V);
        last_pix_s  = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    end

    // Line-buffer read ports, addressed by the current column.
    always_comb begin
        lb0_rd_s = lb0_r[cur_col_s];
        lb1_rd_s = lb1_r[cur_col_s];
    end

    // Next window: each row shifts left, the new column enters on the right.
    always_comb begin
        win_next_s[0] = win_r[1];
        win_next_s[1] = win_r[2];
        win_next_s[2] = lb0_rd_s;
        win_next_s[3] = win_r[4];
        win_next_s[4] = win_r[5];
        win_next_s[5] = lb1_rd_s;
        win_next_s[6] = win_r[7];
        win_next_s[7] = win_r[8];
        win_next_s[8] = pixel_in;
    end

    // Line-buffer write: the row above ages into the r-2 buffer (RAM is never cleared).
    always_ff @(posedge clk) begin
        if (!rst && pixel_valid) begin
            lb1_r[cur_col_s] <= pixel_in;
            lb0_r[cur_col_s] <= lb1_rd_s;
        end
    end

    // Counters, shift window and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r              <= {COL_W{1'b0}};
            row_r              <= {ROW_W{1'b0}};
            start_calculations <= 1'b0;
            frame_done         <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                win_r[k]        <= {PIX_W{1'b0}};
                windowBuffer[k] <= {PIX_W{1'b0}};
            end
        end else if (pixel_valid) begin
            col_r              <= next_col_s;
            row_r              <= next_row_s;
            win_r              <= win_next_s;
            start_calculations <= win_valid_s;
            frame_done         <= last_pix_s;
            if (win_valid_s) begin
                windowBuffer <= win_next_s;
            end
        end else begin
            start_calculations <= 1'b0;
            frame_done         <= 1'b0;
        end
    end

endmodule

// File: doc/sobel_window_generator.md
Name: sobel_window_generator

Overview:
Raster-order pixel streamer that builds the 3x3 neighbourhood the Sobel gradient datapath consumes. It sits upstream of the gradient wrapper. It accepts one 8-bit grayscale pixel per valid cycle and keeps two line buffers plus a 3x3 shift window. For every pixel position where a full 3x3 window lies inside the image, it presents the window and a one-cycle start_calculations pulse.

Parameters:
IMG_WIDTH, 640, pixels per line (>= 3)
IMG_HEIGHT, 480, lines per frame (>= 3)
PIX_W, 8, pixel width in bits

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
pixel_in  input  PIX_W  incoming pixel, raster order (left to right, top to bottom)
pixel_valid  input  1  pixel_in is accepted on this edge
sof  input  1  start of frame; when high with pixel_valid, pixel_in is forced to position (row 0, col 0)
windowBuffer  output  PIX_W x 9 (unpacked [0:8])  3x3 window, row-major, index 0 = top-left
start_calculations  output  1  one-cycle pulse: windowBuffer holds a new valid window
frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset (rst high at a clock edge):
  - col/row counters = 0.
  - windowBuffer all entries = 0.
  - start_calculations = 0, frame_done = 0.
  - Line-buffer RAM contents are don't-care and are not cleared.
  - Reset takes priority over every other input.
- Pixel accept: only on edges with pixel_valid = 1. With pixel_valid = 0 all state holds, start_calculations = 0, frame_done = 0.
- Position tracking: pixel accepted at (row r, col c).
  - col increments each accept and wraps IMG_WIDTH-1 -> 0, with row incrementing on the wrap.
  - row wraps IMG_HEIGHT-1 -> 0, i.e. back-to-back frames need no gap.
  - sof with pixel_valid: the pixel is (0,0) regardless of counters; the counters then continue from (0,1).
- Line buffers:
  - Two buffers, depth IMG_WIDTH.
  - LB1 holds row r-1 and LB0 holds row r-2, both addressed by col.
  - On accept, LB1[c] <= pixel_in and LB0[c] <= old LB1[c].
- Window shift: on accept, each window row shifts left by one column and the new column enters at the right:
  - top row (r-2) gets old LB0[c]
  - middle row (r-1) gets old LB1[c]
  - bottom row (r) gets pixel_in
- Window layout after the accept of (r,c):
  - [0..2] = (r-2, c-2..c)
  - [3..5] = (r-1, c-2..c)
  - [6..8] = (r, c-2..c)
- Valid rule: the window is valid iff r >= 2 and c >= 2. Windows never straddle the line wrap because the c >= 2 gate discards them.
- Latency: windowBuffer and start_calculations are registered. start_calculations = 1 exactly on the cycle after the accepting edge of a valid position.
- windowBuffer holds its last value while start_calculations = 0. The consumer must only sample it when start_calculations = 1.
- Window count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) start_calculations pulses per frame, with no backpressure.
- frame_done: pulses the cycle after accepting (IMG_HEIGHT-1, IMG_WIDTH-1). It coincides with the final start_calculations pulse.
- Mid-frame:
  - sof mid-frame restarts counting. The first window of the new frame appears only after (2,2) of the new frame.
  - Rst mid-frame behaves the same way. No pulses are issued until (2,2) of the next frame.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=4, pixel = r*16+c, continuous valid, sof on first pixel -> first start_calculations the cycle after pixel 0x22. Window = {00,01,02,10,11,12,20,21,22}. Exactly 4 pulses per frame. The last window = {11,12,13,21,22,23,31,32,33}, coincident with frame_done.
- Same stream with pixel_valid low every other cycle -> identical window sequence and contents. No pulses on idle cycles. windowBuffer stable between pulses.
- Two frames back-to-back, second frame pixel = r*16+c+0x80, no sof on frame 2 -> 8 pulses total. The first frame-2 window = {80,81,82,90,91,92,A0,A1,A2}. Two frame_done pulses.
- Assert rst after pixel 0x21 of frame 1, then restart with sof -> outputs zero after the reset edge. The next pulse follows the new frame's pixel (2,2) with correct contents; no stale-row data appears.
- sof asserted at pixel (1,3) mid-frame -> counters resync to (0,0). No pulse until the new (2,2). Window contents come only from the new frame.
- IMG_WIDTH=3, IMG_HEIGHT=3 -> a single pulse whose window equals all 9 pixels in order, plus frame_done on the same cycle.
